instr_prefetch_buffer: RTL and testbench

Instruction prefetch stage between the synchronous instruction ROM and the rv32im core. It generates sequential fetch addresses, issues them to the ROM, which has one cycle of read latency, and queues the returned words with their PCs in a small FIFO. The core consumes them through a valid/ready handshake. A redirect (branch, jump or trap) flushes all queued and in-flight words and restarts fetch at the new PC.

---
 rtl/instr_prefetch_buffer_pkg.sv | 41 ++++
 rtl/instr_prefetch_buffer_sync_fifo.sv | 56 +++++
 rtl/instr_prefetch_buffer.sv | 124 ++++++++++++
 tb/tb_instr_prefetch_buffer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_prefetch_buffer_pkg.sv
// Shared definitions for the instruction prefetch stage.
//
// Provides the API width macros (API_PC_WIDTH, API_DATA_WIDTH,
// API_PREFETCH_DEPTH, API_INSTR_BYTES) when no project-wide definitions
// header has set them already. Also provides the localparams derived from
// them, the packed FIFO entry type and a PC alignment helper.
// The optional output bypass is selected by the API_PREFETCH_BYPASS_EN macro
// (see instr_prefetch_buffer.sv).

`ifndef API_PC_WIDTH
`define API_PC_WIDTH 32
`endif
`ifndef API_DATA_WIDTH
`define API_DATA_WIDTH 32
`endif
`ifndef API_PREFETCH_DEPTH
`define API_PREFETCH_DEPTH 4
`endif
`ifndef API_INSTR_BYTES
`define API_INSTR_BYTES 4
`endif

package instr_prefetch_buffer_pkg;

  localparam int PC_W           = `API_PC_WIDTH;
  localparam int DATA_W         = `API_DATA_WIDTH;
  localparam int PREFETCH_DEPTH = `API_PREFETCH_DEPTH;
  localparam int INSTR_BYTES    = `API_INSTR_BYTES;

  // One queued fetch result: the word and the address it was read from.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] word;
  } fetch_entry_t;

  // Clear the byte-offset bits so fetch always runs on word boundaries.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return pc & ~PC_W'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/instr_prefetch_buffer_sync_fifo.sv
// sync_fifo: single-clock FIFO with a combinational head read.
//
// Ports:
//   clk    in   clock
//   clear  in   empty the FIFO; takes priority over push and pop
//   push   in   write din at the tail (caller guarantees not full)
//   pop    in   drop the head entry (caller guarantees not empty)
//   din    in   WIDTH-bit write data
//   head   out  WIDTH-bit oldest entry, valid while count != 0
//   count  out  number of occupied entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  always_ff @(posedge clk) begin
    if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage carries data only, so it is never reset.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_prefetch_buffer.sv
// instr_prefetch_buffer: sequential instruction prefetch between the
// synchronous instruction ROM (one cycle read latency) and the core.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   redirect_i            flush everything and restart fetch at redirect_pc_i
//   redirect_pc_i         new fetch PC (byte-offset bits ignored)
//   rom_en_o, rom_addr_o  ROM read request and address (fetch_pc)
//   rom_data_i            ROM word, valid the cycle after rom_en_o
//   instr_valid_o         instruction presented to the core
//   instr_o, instr_pc_o   instruction word and its PC
//   instr_ready_i         core accepts the instruction
//   fifo_count_o          occupied FIFO entries
//
// Build option: define API_PREFETCH_BYPASS_EN to present a returning ROM word
// directly when the FIFO is empty (one cycle less latency). Without it, the
// core always sees the FIFO head.

module instr_prefetch_buffer
  import instr_prefetch_buffer_pkg::*;
#(
  parameter int              DEPTH    = PREFETCH_DEPTH,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect_i,
  input  logic [PC_W-1:0]          redirect_pc_i,
  output logic                     rom_en_o,
  output logic [PC_W-1:0]          rom_addr_o,
  input  logic [DATA_W-1:0]        rom_data_i,
  output logic                     instr_valid_o,
  output logic [DATA_W-1:0]        instr_o,
  output logic [PC_W-1:0]          instr_pc_o,
  input  logic                     instr_ready_i,
  output logic [$clog2(DEPTH):0]   fifo_count_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_LIM = (CW+1)'(DEPTH);

  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] pending_pc;
  logic            inflight;
  logic            issue;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_clear;
  logic [CW-1:0]   count;
  logic [CW:0]     occupancy;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;

  // Queued plus in-flight words never exceed DEPTH, so a response always
  // has a free slot when it lands.
  assign occupancy  = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue      = !reset && !redirect_i && (occupancy < DEPTH_LIM);
  assign rom_en_o   = issue;
  assign rom_addr_o = fetch_pc;
  assign fifo_clear = reset || redirect_i;
  assign fifo_count_o = count;
  assign push_entry = '{pc: pending_pc, word: rom_data_i};

  // Stage boundary: issue -> ROM response (fetch_pc, pending_pc, inflight)
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
    end else if (redirect_i) begin
      fetch_pc <= align_pc(redirect_pc_i);
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) fetch_pc <= fetch_pc + PC_W'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (issue) pending_pc <= fetch_pc;
  end

`ifdef API_PREFETCH_BYPASS_EN
  logic bypass;
  logic take;

  // A returning word with nothing queued ahead of it goes straight out;
  // if the core takes it now it never enters the FIFO.
  always_comb begin
    bypass        = (count == '0) && inflight;
    instr_valid_o = !reset && !redirect_i && ((count != '0) || inflight);
    instr_o       = head.word;
    instr_pc_o    = head.pc;
    if (bypass) begin
      instr_o    = rom_data_i;
      instr_pc_o = pending_pc;
    end
  end

  assign take      = instr_valid_o && instr_ready_i;
  assign fifo_pop  = take && (count != '0);
  assign fifo_push = inflight && !redirect_i && !(take && bypass);
`else
  assign instr_valid_o = !reset && !redirect_i && (count != '0);
  assign instr_o       = head.word;
  assign instr_pc_o    = head.pc;
  assign fifo_pop      = instr_valid_o && instr_ready_i;
  assign fifo_push     = inflight && !redirect_i;
`endif

  // Stage boundary: ROM response -> queued for the core
  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clear (fifo_clear),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (push_entry),
    .head  (head),
    .count (count)
  );

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Scoreboard bench for instr_prefetch_buffer (DEPTH=4, RESET_PC=0, 32-bit PC).
// Inputs change #1 after the rising edge; outputs are observed on the falling edge.
module tb_instr_prefetch_buffer;
  import instr_prefetch_buffer_pkg::*;

`ifdef API_PREFETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        rom_en_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;
  logic [2:0]  fifo_count_o;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          pops   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  instr_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .rom_en_o      (rom_en_o),
    .rom_addr_o    (rom_addr_o),
    .rom_data_i    (rom_data_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i),
    .fifo_count_o  (fifo_count_o)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A0F_3C00;
  endfunction

  // ROM model: one cycle read latency, poison when not enabled.
  always @(posedge clk) rom_data_i <= rom_en_o ? rom_word(rom_addr_o) : 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake is checked against the expected-PC queue.
  always @(negedge clk) begin
    logic [31:0] e;
    if (instr_valid_o && instr_ready_i) begin
      pops++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_pop: got pc %0h expected none", instr_pc_o);
      end else begin
        e = exp_q.pop_front();
        check("pop_pc", instr_pc_o, e);
        check("pop_word", instr_o, rom_word(e));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic consume(input int n);
    int target;
    int k;
    target = pops + n;
    k = 0;
    instr_ready_i = 1'b1;
    while (pops < target && k < 60) begin
      step();
      k++;
    end
    instr_ready_i = 1'b0;
    check("consume_done", 32'(pops >= target), 32'd1);
  endtask

  initial begin
    int k;
    reset = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; instr_ready_i = 1'b0;
    repeat (2) step();
    @(negedge clk);
    check("rst_rom_en", 32'(rom_en_o), 32'd0);
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_count", 32'(fifo_count_o), 32'd0);
    check("rst_addr", rom_addr_o, 32'h0);

    // Streaming with ready held high
    step(); reset = 1'b0; instr_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    @(negedge clk);
    check("c0_rom_en", 32'(rom_en_o), 32'd1);
    check("c0_addr", rom_addr_o, 32'h0);
    check("c0_valid", 32'(instr_valid_o), 32'd0);
    step(); @(negedge clk);
    check("c1_addr", rom_addr_o, 32'h4);
    check("c1_valid", 32'(instr_valid_o), 32'(BYP));
    step(); @(negedge clk);
    check("c2_addr", rom_addr_o, 32'h8);
    check("c2_valid", 32'(instr_valid_o), 32'd1);
    k = 0;
    while (pops < 8 && k < 40) begin
      step();
      k++;
    end
    instr_ready_i = 1'b0;
    check("stream_cycles", 32'(k), 32'(8 - BYP));

    // Backpressure: ready low for 10 cycles after a fresh reset
    reset = 1'b1; exp_q.delete();
    step(); reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 3) check("bp_en_c3", 32'(rom_en_o), 32'd1);
      if (c == 4) begin
        check("bp_en_c4", 32'(rom_en_o), 32'd0);
        check("bp_cnt_c4", 32'(fifo_count_o), 32'd3);
      end
      if (c == 9) begin
        check("bp_en_c9", 32'(rom_en_o), 32'd0);
        check("bp_cnt_c9", 32'(fifo_count_o), 32'd4);
      end
      if (c < 9) step();
    end
    step();
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
    consume(6);

    // Redirect while count=3 and a response is in flight
    reset = 1'b1; exp_q.delete();
    step(); reset = 1'b0;
    repeat (4) step();
    redirect_i = 1'b1; redirect_pc_i = 32'h103;
    @(negedge clk);
    check("rd_pre_count", 32'(fifo_count_o), 32'd3);
    check("rd_valid", 32'(instr_valid_o), 32'd0);
    check("rd_rom_en", 32'(rom_en_o), 32'd0);
    step(); redirect_i = 1'b0;
    exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
    @(negedge clk);
    check("rd_count", 32'(fifo_count_o), 32'd0);
    check("rd_addr", rom_addr_o, 32'h100);
    check("rd_rom_en_next", 32'(rom_en_o), 32'd1);
    step();
    consume(3);

    // Redirect in the same cycle as a pop handshake
    step(); step();
    redirect_i = 1'b1; redirect_pc_i = 32'h200; instr_ready_i = 1'b1;
    exp_q.delete(); exp_q.push_back(32'h200); exp_q.push_back(32'h204);
    @(negedge clk);
    check("rp_pre_nonempty", 32'(fifo_count_o != 3'd0), 32'd1);
    check("rp_valid", 32'(instr_valid_o), 32'd0);
    step(); redirect_i = 1'b0;
    @(negedge clk);
    check("rp_count", 32'(fifo_count_o), 32'd0);
    step();
    consume(2);

    // Fetch address wrap
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC; exp_q.delete();
    step(); redirect_i = 1'b0;
    @(negedge clk);
    check("wrap_addr0", rom_addr_o, 32'hFFFF_FFFC);
    step(); @(negedge clk);
    check("wrap_addr1", rom_addr_o, 32'h0);
    step();
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    consume(3);

    // Reset mid-stream with three words queued
    redirect_i = 1'b1; redirect_pc_i = 32'h40; exp_q.delete();
    step(); redirect_i = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    @(negedge clk);
    check("mr_pre_count", 32'(fifo_count_o), 32'd3);
    step(); reset = 1'b0;
    @(negedge clk);
    check("mr_count", 32'(fifo_count_o), 32'd0);
    check("mr_valid", 32'(instr_valid_o), 32'd0);
    check("mr_addr", rom_addr_o, 32'h0);
    step();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    consume(2);

    repeat (3) step();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
